// File: rtl/disp_pkg.sv
// Shared constants for the stopwatch display multiplexer: active-low segment
// patterns {dp,g,f,e,d,c,b,a} and the all-off anode pattern.
package disp_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_B     = 8'h83;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Active-low one-hot anode pattern for a digit slot.
  function automatic logic [3:0] an_for_slot(input logic [1:0] sel);
    return ~(4'b0001 << sel);
  endfunction

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational hex digit to active-low seven-segment {g..a} decoder.
// Values 10-15 render as hex glyphs A, b, C, d, E, F.
module hex_to_sseg
  import disp_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Glyph lookup.
  always_comb begin
    seg = SEG_BLANK[6:0];
    case (hex)
      4'h0:    seg = SEG_0[6:0];
      4'h1:    seg = SEG_1[6:0];
      4'h2:    seg = SEG_2[6:0];
      4'h3:    seg = SEG_3[6:0];
      4'h4:    seg = SEG_4[6:0];
      4'h5:    seg = SEG_5[6:0];
      4'h6:    seg = SEG_6[6:0];
      4'h7:    seg = SEG_7[6:0];
      4'h8:    seg = SEG_8[6:0];
      4'h9:    seg = SEG_9[6:0];
      4'hA:    seg = SEG_A[6:0];
      4'hB:    seg = SEG_B[6:0];
      4'hC:    seg = SEG_C[6:0];
      4'hD:    seg = SEG_D[6:0];
      4'hE:    seg = SEG_E[6:0];
      4'hF:    seg = SEG_F[6:0];
      default: seg = SEG_BLANK[6:0];
    endcase
  end

endmodule

// File: rtl/stopwatch_disp_mux.sv
// Time-multiplexed 4-digit common-anode display driver with per-frame digit
// snapshot. Optional leading-zero blanking under DISP_LEADING_ZERO_BLANK_EN.
module stopwatch_disp_mux
  import disp_pkg::*;
#(
  parameter int N = 18  // refresh counter width, must be >= 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d3,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  input  logic [3:0] dp_in,
  output logic [3:0] an,
  output logic [7:0] sseg
);

  localparam logic [N-1:0] Q_LAST = {N{1'b1}};
  localparam logic [N-1:0] Q_ONE  = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] q_r;
  logic [15:0]  shadow_r;
  logic [3:0]   shadow_dp_r;
  logic [3:0]   an_r;
  logic [7:0]   sseg_r;
  logic [1:0]   sel_s;
  logic [3:0]   digit_s;
  logic [6:0]   seg_s;
  logic         blank_s;

  assign sel_s = q_r[N-1:N-2];

  // Free-running refresh counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r <= {N{1'b0}};
    end else begin
      q_r <= q_r + Q_ONE;
    end
  end

  // Capture all digits together on the last count so a frame never tears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_r    <= 16'h0000;
      shadow_dp_r <= 4'b0000;
    end else if (q_r == Q_LAST) begin
      shadow_r    <= {d3, d2, d1, d0};
      shadow_dp_r <= dp_in;
    end else begin
      shadow_r    <= shadow_r;
      shadow_dp_r <= shadow_dp_r;
    end
  end

  // Shadow digit for the active slot.
  always_comb begin
    digit_s = 4'h0;
    case (sel_s)
      2'd0:    digit_s = shadow_r[3:0];
      2'd1:    digit_s = shadow_r[7:4];
      2'd2:    digit_s = shadow_r[11:8];
      2'd3:    digit_s = shadow_r[15:12];
      default: digit_s = 4'h0;
    endcase
  end

  hex_to_sseg u_hex_to_sseg (
    .hex (digit_s),
    .seg (seg_s)
  );

`ifdef DISP_LEADING_ZERO_BLANK_EN
  // A slot goes dark when it and everything left of it is zero and its dp is off.
  always_comb begin
    blank_s = 1'b0;
    case (sel_s)
      2'd3:    blank_s = (shadow_r[15:12] == 4'h0)   && !shadow_dp_r[3];
      2'd2:    blank_s = (shadow_r[15:8]  == 8'h00)  && !shadow_dp_r[2];
      2'd1:    blank_s = (shadow_r[15:4]  == 12'h000) && !shadow_dp_r[1];
      default: blank_s = 1'b0;
    endcase
  end
`else
  // All digits always lit.
  always_comb begin
    blank_s = 1'b0;
  end
`endif

  // Registered anode/segment drive, one clock behind the counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_r   <= AN_OFF;
      sseg_r <= SEG_BLANK;
    end else if (blank_s) begin
      an_r   <= AN_OFF;
      sseg_r <= SEG_BLANK;
    end else begin
      an_r   <= an_for_slot(sel_s);
      sseg_r <= {~shadow_dp_r[sel_s], seg_s};
    end
  end

  assign an   = an_r;
  assign sseg = sseg_r;

endmodule
